// File: rtl/trace_capture_ctrl_pkg.sv
// Shared types for the retire-trace capture controller.
// Holds the FSM state enum, the trace entry width and the entry packer.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_e;

    localparam int TRACE_ENTRY_W = 64;

    // Trace entry layout: PC in the upper word, encoding in the lower.
    function automatic logic [TRACE_ENTRY_W-1:0] pack_entry(
        input logic [31:0] pc,
        input logic [31:0] instr
    );
        return {pc, instr};
    endfunction

endpackage

// File: rtl/trace_capture_ctrl_if.sv
// Retire-in / trace-buffer-write-out bundle of the capture controller.
// master: the controller (reads retire, drives buffer writes); slave: the core/buffer side.
interface trace_capture_ctrl_if
    import trace_pkg::*;
#(
    parameter int PTR_BITS = 8
);
    logic                     retire_valid_i;
    logic [31:0]              retire_pc_i;
    logic [31:0]              retire_instr_i;
    logic                     buf_we_o;
    logic [PTR_BITS-1:0]      buf_waddr_o;
    logic [TRACE_ENTRY_W-1:0] buf_wdata_o;

    modport master (
        input  retire_valid_i,
        input  retire_pc_i,
        input  retire_instr_i,
        output buf_we_o,
        output buf_waddr_o,
        output buf_wdata_o
    );

    modport slave (
        output retire_valid_i,
        output retire_pc_i,
        output retire_instr_i,
        input  buf_we_o,
        input  buf_waddr_o,
        input  buf_wdata_o
    );
endinterface

// File: rtl/trace_capture_ctrl.sv
// Retire-trace capture controller: records retired instructions into an
// external circular trace buffer and freezes post_count entries after a trigger.
// Ports: clk_i, rst_i (sync, active-high); bus (retire in, buffer write out);
// arm_i/disarm_i/trig_en_i/trig_pc_i/sw_trig_i/post_count_i control;
// triggered_o/done_o/wrapped_o/wr_ptr_o/trig_idx_o status.
module trace_capture_ctrl
    import trace_pkg::*;
#(
    parameter int TRACE_DEPTH = 256,
    parameter int PTR_BITS    = $clog2(TRACE_DEPTH)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    trace_capture_ctrl_if.master bus,
    input  logic                arm_i,
    input  logic                disarm_i,
    input  logic                trig_en_i,
    input  logic [31:0]         trig_pc_i,
    input  logic                sw_trig_i,
    input  logic [PTR_BITS-1:0] post_count_i,
    output logic                triggered_o,
    output logic                done_o,
    output logic                wrapped_o,
    output logic [PTR_BITS-1:0] wr_ptr_o,
    output logic [PTR_BITS-1:0] trig_idx_o
);

    localparam logic [PTR_BITS-1:0] LAST_IDX = PTR_BITS'(TRACE_DEPTH - 1);
    localparam logic [PTR_BITS-1:0] ONE      = PTR_BITS'(1);

    trace_state_e        state;
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] trig_idx;
    logic [PTR_BITS-1:0] remaining;
    logic                triggered;
    logic                wrapped;

    logic do_write;
    logic trig_fire;

    // arm/disarm take priority over the FSM, so they also block the write.
    always_comb begin
        do_write  = 1'b0;
        trig_fire = 1'b0;
        if (!disarm_i && !arm_i &&
            (state == ST_ARMED || state == ST_POST))
            do_write = bus.retire_valid_i;
        if (sw_trig_i)
            trig_fire = 1'b1;
        if (bus.retire_valid_i && trig_en_i &&
            bus.retire_pc_i == trig_pc_i)
            trig_fire = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= ST_IDLE;
            wr_ptr          <= '0;
            trig_idx        <= '0;
            remaining       <= '0;
            triggered       <= 1'b0;
            wrapped         <= 1'b0;
            bus.buf_we_o    <= 1'b0;
            bus.buf_waddr_o <= '0;
            bus.buf_wdata_o <= '0;
        end else begin
            bus.buf_we_o <= 1'b0;
            if (do_write) begin
                bus.buf_we_o    <= 1'b1;
                bus.buf_waddr_o <= wr_ptr;
                bus.buf_wdata_o <= pack_entry(bus.retire_pc_i,
                                              bus.retire_instr_i);
                wr_ptr          <= wr_ptr + ONE;
                if (wr_ptr == LAST_IDX)
                    wrapped <= 1'b1;
            end

            if (disarm_i) begin
                state <= ST_IDLE;
            end else if (arm_i) begin
                state     <= ST_ARMED;
                wr_ptr    <= '0;
                trig_idx  <= '0;
                remaining <= '0;
                triggered <= 1'b0;
                wrapped   <= 1'b0;
            end else begin
                unique case (state)
                    ST_ARMED: begin
                        if (trig_fire) begin
                            triggered <= 1'b1;
                            trig_idx  <= wr_ptr;
                            remaining <= post_count_i;
                            state     <= (post_count_i == '0) ?
                                         ST_DONE : ST_POST;
                        end
                    end
                    ST_POST: begin
                        // remaining is never 0 here: a zero count goes straight to DONE.
                        if (bus.retire_valid_i) begin
                            remaining <= remaining - ONE;
                            if (remaining == ONE)
                                state <= ST_DONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign triggered_o = triggered;
    assign done_o      = (state == ST_DONE);
    assign wrapped_o   = wrapped;
    assign wr_ptr_o    = wr_ptr;
    assign trig_idx_o  = trig_idx;

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Self-checking bench for trace_capture_ctrl at TRACE_DEPTH=8.
// Per-cycle vector table for status; buffer writes checked through a scoreboard queue.
module tb_trace_capture_ctrl;

    localparam int PB = 3;

    typedef struct {
        bit          rst, arm, dis, ten, sw, rv;
        logic [31:0] pc;
        logic [2:0]  post;
        bit          we;
        logic [2:0]  waddr, ptr;
        bit          trg, dn, wrp;
        logic [2:0]  tidx;
    } vec_t;

    typedef struct {
        logic [2:0]  a;
        logic [63:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic arm = 1'b0, dis = 1'b0, ten = 1'b0, sw = 1'b0;
    logic [31:0] trig_pc = 32'h40;
    logic [PB-1:0] post = '0;
    logic triggered, done, wrapped;
    logic [PB-1:0] wr_ptr, trig_idx;

    vec_t vecs[$];
    wr_t  sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    trace_capture_ctrl_if #(.PTR_BITS(PB)) bus ();

    trace_capture_ctrl #(.TRACE_DEPTH(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .bus          (bus),
        .arm_i        (arm),
        .disarm_i     (dis),
        .trig_en_i    (ten),
        .trig_pc_i    (trig_pc),
        .sw_trig_i    (sw),
        .post_count_i (post),
        .triggered_o  (triggered),
        .done_o       (done),
        .wrapped_o    (wrapped),
        .wr_ptr_o     (wr_ptr),
        .trig_idx_o   (trig_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0], 16'h0513};
    endfunction

    task automatic add(input bit r, a, d, t, s, v,
                       input logic [31:0] pc, input int pst,
                       input bit we, input int wa, input int p,
                       input bit tg, input bit dn, input bit wp,
                       input int ti);
        vec_t x;
        x.rst = r; x.arm = a; x.dis = d; x.ten = t; x.sw = s; x.rv = v;
        x.pc = pc; x.post = 3'(pst); x.we = we; x.waddr = 3'(wa);
        x.ptr = 3'(p); x.trg = tg; x.dn = dn; x.wrp = wp; x.tidx = 3'(ti);
        vecs.push_back(x);
    endtask

    task automatic chk(input int row, input string nm,
                       input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL row%0d %s: got %0h expected %0h",
                     row, nm, act, exp);
        end
    endtask

    initial begin
        wr_t e;
        bus.retire_valid_i = 1'b0;
        bus.retire_pc_i    = '0;
        bus.retire_instr_i = '0;

        // reset
        add(1,0,0,0,0,0,0,0,      0,0,0,0,0,0,0);
        // three retires, no wrap
        add(0,1,0,0,0,0,0,0,      0,0,0,0,0,0,0);
        add(0,0,0,0,0,1,'h10,0,   1,0,1,0,0,0,0);
        add(0,0,0,0,0,1,'h14,0,   1,1,2,0,0,0,0);
        add(0,0,0,0,0,1,'h18,0,   1,2,3,0,0,0,0);
        add(0,0,0,0,0,0,0,0,      0,0,3,0,0,0,0);
        // ten retires, circular recording
        add(0,1,0,0,0,0,0,0,      0,0,0,0,0,0,0);
        for (int i = 0; i < 10; i++)
            add(0,0,0,0,0,1,32'h100 + 4*i,0,
                1,i%8,(i+1)%8,0,0,(i>=7),0);
        add(0,0,0,0,0,0,0,0,      0,0,2,0,0,1,0);
        // PC trigger, post_count=2
        add(0,1,0,0,0,0,0,0,      0,0,0,0,0,0,0);
        add(0,0,0,1,0,1,'h38,2,   1,0,1,0,0,0,0);
        add(0,0,0,1,0,1,'h3C,2,   1,1,2,0,0,0,0);
        add(0,0,0,1,0,1,'h40,2,   1,2,3,1,0,0,2);
        add(0,0,0,1,0,1,'h44,2,   1,3,4,1,0,0,2);
        add(0,0,0,1,0,1,'h48,2,   1,4,5,1,1,0,2);
        add(0,0,0,1,0,1,'h4C,2,   0,0,5,1,1,0,2);
        // PC trigger, post_count=0
        add(0,1,0,0,0,0,0,0,      0,0,0,0,0,0,0);
        add(0,0,0,1,0,1,'h40,0,   1,0,1,1,1,0,0);
        add(0,0,0,1,0,1,'h44,0,   0,0,1,1,1,0,0);
        add(0,0,0,1,0,1,'h40,0,   0,0,1,1,1,0,0);
        // arm+disarm together in POST
        add(0,1,0,0,0,0,0,0,      0,0,0,0,0,0,0);
        add(0,0,0,1,0,1,'h40,3,   1,0,1,1,0,0,0);
        add(0,0,0,1,0,1,'h44,3,   1,1,2,1,0,0,0);
        add(0,1,1,1,0,1,'h48,3,   0,0,2,1,0,0,0);
        add(0,0,0,1,0,1,'h4C,3,   0,0,2,1,0,0,0);
        add(0,0,0,0,1,0,0,3,      0,0,2,1,0,0,0);
        // reset during a retire in ARMED
        add(0,1,0,0,0,0,0,0,      0,0,0,0,0,0,0);
        add(0,0,0,0,0,1,'h10,0,   1,0,1,0,0,0,0);
        add(1,0,0,0,0,1,'h14,0,   0,0,0,0,0,0,0);
        add(0,0,0,0,0,1,'h18,0,   0,0,0,0,0,0,0);
        // software trigger with and without a retire; re-arm from DONE
        add(0,1,0,0,0,0,0,0,      0,0,0,0,0,0,0);
        add(0,0,0,0,1,1,'h20,1,   1,0,1,1,0,0,0);
        add(0,0,0,0,1,1,'h24,1,   1,1,2,1,1,0,0);
        add(0,1,0,0,0,1,'h28,1,   0,0,0,0,0,0,0);
        add(0,0,0,0,1,0,0,2,      0,0,0,1,0,0,0);
        add(0,0,0,0,0,1,'h30,2,   1,0,1,1,0,0,0);
        add(0,0,0,0,0,1,'h34,2,   1,1,2,1,1,0,0);
        // disarm in ARMED holds the pointer
        add(0,1,0,0,0,0,0,0,      0,0,0,0,0,0,0);
        add(0,0,0,0,0,1,'h50,0,   1,0,1,0,0,0,0);
        add(0,0,1,0,0,1,'h54,0,   0,0,1,0,0,0,0);
        add(0,0,0,0,0,1,'h58,0,   0,0,1,0,0,0,0);

        @(negedge clk);
        foreach (vecs[k]) begin
            rst = vecs[k].rst; arm = vecs[k].arm; dis = vecs[k].dis;
            ten = vecs[k].ten; sw = vecs[k].sw; post = vecs[k].post;
            bus.retire_valid_i = vecs[k].rv;
            bus.retire_pc_i    = vecs[k].pc;
            bus.retire_instr_i = instr_of(vecs[k].pc);
            if (vecs[k].we) begin
                e.a = vecs[k].waddr;
                e.d = {vecs[k].pc, instr_of(vecs[k].pc)};
                sb.push_back(e);
            end
            @(posedge clk);
            @(negedge clk);
            chk(k, "buf_we", 64'(bus.buf_we_o), 64'(vecs[k].we));
            if (bus.buf_we_o || vecs[k].we) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL row%0d unexpected_write: addr %0h",
                             k, bus.buf_waddr_o);
                end else begin
                    e = sb.pop_front();
                    if (bus.buf_we_o) begin
                        chk(k, "buf_waddr", 64'(bus.buf_waddr_o), 64'(e.a));
                        chk(k, "buf_wdata", bus.buf_wdata_o, e.d);
                    end
                end
            end
            if (vecs[k].rst) begin
                chk(k, "rst_waddr", 64'(bus.buf_waddr_o), 64'd0);
                chk(k, "rst_wdata", bus.buf_wdata_o, 64'd0);
            end
            chk(k, "wr_ptr",    64'(wr_ptr),    64'(vecs[k].ptr));
            chk(k, "triggered", 64'(triggered), 64'(vecs[k].trg));
            chk(k, "done",      64'(done),      64'(vecs[k].dn));
            chk(k, "wrapped",   64'(wrapped),   64'(vecs[k].wrp));
            chk(k, "trig_idx",  64'(trig_idx),  64'(vecs[k].tidx));
        end
        chk(-1, "sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/trace_capture_ctrl.md
TRACE_CAPTURE_CTRL -- requirements
Module: trace_capture_ctrl

Interface
REQ-001 SHALL have parameter TRACE_DEPTH, default 256: trace buffer entries, power of two, minimum 4.
REQ-002 SHALL have parameter PTR_BITS, default $clog2(TRACE_DEPTH): write-pointer width.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk_i  in  1  clock; all state updates on rising edge.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 retire_valid_i  in  1  one instruction retired this cycle.
REQ-007 retire_pc_i  in  32  PC of the retiring instruction.
REQ-008 retire_instr_i  in  32  encoding of the retiring instruction.
REQ-009 arm_i  in  1  pulse; start a fresh capture.
REQ-010 disarm_i  in  1  pulse; abort capture, return to IDLE.
REQ-011 trig_en_i  in  1  enable PC-match trigger.
REQ-012 trig_pc_i  in  32  trigger PC.
REQ-013 sw_trig_i  in  1  pulse; software trigger.
REQ-014 post_count_i  in  PTR_BITS  entries to capture after the trigger entry.
REQ-015 buf_we_o  out  1  trace buffer write enable.
REQ-016 buf_waddr_o  out  PTR_BITS  trace buffer write address.
REQ-017 buf_wdata_o  out  64  {pc[63:32], instr[31:0]}.
REQ-018 triggered_o  out  1  trigger seen in this capture.
REQ-019 done_o  out  1  capture frozen.
REQ-020 wrapped_o  out  1  pointer has wrapped at least once since arm.
REQ-021 wr_ptr_o  out  PTR_BITS  next write address.
REQ-022 trig_idx_o  out  PTR_BITS  address holding the trigger entry (or next write address on a software trigger).

Function
REQ-023 States: IDLE, ARMED, POST, DONE; writes occur only in ARMED and POST.
REQ-024 Write latency: exactly 1 cycle; retire_valid_i at edge N gives buf_we_o=1 during cycle N+1 with the registered address and data.
REQ-025 Each write advances wr_ptr_o by 1, modulo TRACE_DEPTH; a write at TRACE_DEPTH-1 sets wrapped_o, and wrapped_o stays set until the next arm or reset.
REQ-026 IDLE->ARMED on arm_i: wr_ptr, triggered, wrapped and trig_idx are cleared.
REQ-027 arm_i in ARMED, POST or DONE restarts the capture exactly as in REQ-026; no write from that cycle's retire.
REQ-028 disarm_i in any state -> IDLE, no write that cycle, and wr_ptr, triggered and wrapped are held.
REQ-029 disarm_i and arm_i in the same cycle: disarm wins.
REQ-030 ARMED, retire_valid_i, trig_en_i and retire_pc_i==trig_pc_i: entry written, trig_idx=current wr_ptr, triggered=1, remaining=post_count_i, and -> POST, or -> DONE if post_count_i==0.
REQ-031 ARMED, sw_trig_i with no PC match: triggered=1, trig_idx=wr_ptr, remaining=post_count_i, -> POST (-> DONE if 0); a same-cycle retire is still written.
REQ-032 POST, retire_valid_i: entry written and remaining decremented; -> DONE when the write makes remaining 0.
REQ-033 POST ignores further PC matches and sw_trig_i; post_count_i is sampled only at the trigger.
REQ-034 DONE: no writes and all outputs held; done_o=1 only in DONE.
REQ-035 With trig_en_i=0, the ARMED state records circularly and indefinitely.

Reset
REQ-036 rst_i SHALL force IDLE, all outputs to 0 and remaining to 0; a write pending from the previous cycle SHALL be suppressed.
REQ-037 Reset mid-capture SHALL discard the capture; arm_i SHALL be required afterwards.

Structure
REQ-038 Package trace_pkg SHALL hold the state enum (2 bits), TRACE_ENTRY_W=64 and the entry packing helper.
REQ-039 No sub-module; the trace buffer memory stays external (the existing trace buffer inside Debug_Telemetry).

Verification
REQ-040 TRACE_DEPTH=8, arm, 3 retires with PCs 0x10, 0x14, 0x18 -> writes to addresses 0,1,2 one cycle later, wr_ptr_o=3, wrapped_o=0.
REQ-041 TRACE_DEPTH=8, arm, 10 retires, trig_en=0 -> addresses 0..7,0,1; wrapped_o=1 after the 8th write; wr_ptr_o=2.
REQ-042 trig_pc=0x40, post_count=2, retires 0x38, 0x3C, 0x40, 0x44, 0x48, 0x4C -> trig_idx_o=2, DONE after the 0x48 write, 0x4C not written, wr_ptr_o=5.
REQ-043 post_count=0 and a PC match -> only the trigger entry is written, done_o=1 the next cycle, and later retires produce no buf_we_o.
REQ-044 In POST, disarm_i and arm_i together -> IDLE, triggered_o held at 1, and no write.
REQ-045 rst_i asserted in the same cycle as a retire in ARMED -> buf_we_o=0 next cycle, all outputs 0, state IDLE.
